cv32e40s_lfsr_ctrl: RTL and testbench
=====================================

Name: cv32e40s_lfsr_ctrl

Overview:
- Owns and sequences the three 32-bit pseudo-random LFSRs used by the security features: dummy/hint instruction generation and dummy cadence.
- Arbitrates each LFSR between CSR seed writes and shift requests from the pipeline.
- Repairs all-zero lockup.
- Generates the counter-reset pulse consumed by the dummy instruction generator.
- Sits beside the CSR file; its outputs feed the xsecure_ctrl bundle.

Parameters:
- LFSR0_SEED, 32'h1234_5678, reset/recovery value of lfsr0
- LFSR1_SEED, 32'h9ABC_DEF0, reset/recovery value of lfsr1
- LFSR2_SEED, 32'h0F1E_2D3C, reset/recovery value of lfsr2
- LFSR_POLY, 32'h8020_0003, Galois feedback polynomial shared by all three LFSRs (maximal length)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- seed_we_i  in  3  per-LFSR seed write strobe from CSR file (bit N selects lfsrN)
- seed_wdata_i  in  32  seed value for any strobed LFSR
- cpuctrl_we_i  in  1  cpuctrl CSR written (dummy enable/frequency may have changed)
- shift_i  in  3  per-LFSR shift request (dummy or hint leaving ID)
- lfsr0_o  out  32  current lfsr0 value
- lfsr1_o  out  32  current lfsr1 value
- lfsr2_o  out  32  current lfsr2 value
- cntrst_o  out  1  one-cycle request to reset the dummy interval counter
- lockup_o  out  3  per-LFSR one-cycle lockup-recovery pulse

Behaviour:
- Reset values:
  - lfsrN_o = LFSRN_SEED
  - cntrst_o = 0
  - lockup_o = 3'b000
- All outputs are registered; no combinational input-to-output path.
- Shift step: next = {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0).
- Per-LFSR priority each cycle, evaluated independently per N:
  - seed_we_i[N]: candidate = seed_wdata_i.
  - else shift_i[N]: candidate = step(v).
  - else: hold.
  - Seed write and shift in the same cycle: the shift is dropped, not deferred.
- Lockup check on the candidate value only when an update occurs:
  - If candidate == 0, the register loads LFSRN_SEED instead.
  - lockup_o[N] is 1 in the following cycle, for exactly one cycle.
  - Reachable only via seed write of 0, since shift of a nonzero value never yields 0 with this poly. The check still covers both paths.
- Latency: new value is visible on lfsrN_o one cycle after the request.
- cntrst_o is 1 in the cycle after (cpuctrl_we_i || seed_we_i[0]); otherwise 0.
  - Back-to-back triggers give back-to-back pulses.
  - lfsr1/lfsr2 writes do not assert it.
- Multiple seed strobes in one cycle load the same wdata into every strobed LFSR.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous); pending requests are lost.

Optional Feature:
- Macro: CV32E40S_LFSR_LOCKUP_ALERT_EN.
- With the macro defined:
  - Extra output alert_minor_o (1 bit, registered, reset 0) pulses for one cycle whenever any lockup_o bit pulses.
  - A sticky 3-bit lockup_seen status register is set per LFSR on lockup and cleared only by reset.
  - The status register is exposed as lockup_seen_o.
- Without the macro: alert_minor_o and lockup_seen_o are absent; recovery behaviour is identical.

Decomposition:
- cv32e40s_pkg gains:
  - LFSR_POLY_DEFAULT and the three default seeds as localparams.
  - typedef lfsr_req_t {logic seed_we; logic shift;}.
- The step function lives in the package as a function so the generator and assertions share it.
- Sub-module cv32e40s_lfsr holds one register, priority mux and lockup check, parameterised by SEED and POLY. It is instantiated three times.
- The top level holds the cntrst and alert logic.

Test Plan:
- Reset release with no requests -> lfsr0_o=32'h1234_5678, lfsr1_o=32'h9ABC_DEF0, lfsr2_o=32'h0F1E_2D3C, cntrst_o=0, lockup_o=0.
- seed_we_i=3'b001, wdata=32'h0000_0001, then shift_i=3'b001 -> lfsr0_o=32'h0000_0001, then 32'h8020_0003. cntrst_o pulses in the cycle after the write.
- seed_we_i=3'b010 with wdata=32'h0000_0002 and shift_i=3'b010 in the same cycle -> lfsr1_o=32'h0000_0002 (shift dropped). Next shift -> 32'h0000_0001.
- seed_we_i=3'b100, wdata=0 -> lfsr2_o=32'h0F1E_2D3C, lockup_o=3'b100 for one cycle. With the macro defined, alert_minor_o pulses and lockup_seen_o=3'b100 persists.
- cpuctrl_we_i high for 3 consecutive cycles -> cntrst_o high for 3 cycles, delayed by one. seed_we_i=3'b110 -> cntrst_o stays 0.
- shift_i=3'b111 for 1000 cycles from reset -> no lfsrN_o ever 0, lockup_o stays 0, values match the package step function.

Source files
------------

// File: rtl/cv32e40s_lfsr_ctrl_pkg.sv
// Shared LFSR constants, request bundle and Galois step function.
// Used by the LFSR controller, its per-LFSR slice and checkers.
package cv32e40s_lfsr_ctrl_pkg;

  localparam logic [31:0] LFSR_POLY_DEFAULT  = 32'h8020_0003;
  localparam logic [31:0] LFSR0_SEED_DEFAULT = 32'h1234_5678;
  localparam logic [31:0] LFSR1_SEED_DEFAULT = 32'h9ABC_DEF0;
  localparam logic [31:0] LFSR2_SEED_DEFAULT = 32'h0F1E_2D3C;

  localparam int unsigned LFSR_NUM = 3;

  typedef struct packed {
    logic seed_we;
    logic shift;
  } lfsr_req_t;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] v,
    input logic [31:0] poly
  );
    logic [31:0] fb;
    fb = v[0] ? poly : 32'h0;
    return {1'b0, v[31:1]} ^ fb;
  endfunction

endpackage

// File: rtl/cv32e40s_lfsr_ctrl_if.sv
// CSR/pipeline-side bundle of the LFSR controller.
// Optional alert signals exist only with CV32E40S_LFSR_LOCKUP_ALERT_EN.
interface cv32e40s_lfsr_ctrl_if;

  logic [2:0]  seed_we_i;
  logic [31:0] seed_wdata_i;
  logic        cpuctrl_we_i;
  logic [2:0]  shift_i;
  logic [31:0] lfsr0_o;
  logic [31:0] lfsr1_o;
  logic [31:0] lfsr2_o;
  logic        cntrst_o;
  logic [2:0]  lockup_o;
`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
  logic        alert_minor_o;
  logic [2:0]  lockup_seen_o;
`endif

`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
  modport master (
    output seed_we_i,
    output seed_wdata_i,
    output cpuctrl_we_i,
    output shift_i,
    input  lfsr0_o,
    input  lfsr1_o,
    input  lfsr2_o,
    input  cntrst_o,
    input  lockup_o,
    input  alert_minor_o,
    input  lockup_seen_o
  );

  modport slave (
    input  seed_we_i,
    input  seed_wdata_i,
    input  cpuctrl_we_i,
    input  shift_i,
    output lfsr0_o,
    output lfsr1_o,
    output lfsr2_o,
    output cntrst_o,
    output lockup_o,
    output alert_minor_o,
    output lockup_seen_o
  );
`else
  modport master (
    output seed_we_i,
    output seed_wdata_i,
    output cpuctrl_we_i,
    output shift_i,
    input  lfsr0_o,
    input  lfsr1_o,
    input  lfsr2_o,
    input  cntrst_o,
    input  lockup_o
  );

  modport slave (
    input  seed_we_i,
    input  seed_wdata_i,
    input  cpuctrl_we_i,
    input  shift_i,
    output lfsr0_o,
    output lfsr1_o,
    output lfsr2_o,
    output cntrst_o,
    output lockup_o
  );
`endif

endinterface

// File: rtl/cv32e40s_lfsr_ctrl_lfsr.sv
// One 32-bit Galois LFSR: seed/shift priority mux and zero-lockup repair.
// Lockup pulse is registered; lock_evt_o is the same-cycle detect for the parent.
module cv32e40s_lfsr
  import cv32e40s_lfsr_ctrl_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR0_SEED_DEFAULT,
  parameter logic [31:0] POLY = LFSR_POLY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  lfsr_req_t   req_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lfsr_o,
  output logic        lockup_o,
  output logic        lock_evt_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] cand;
  logic        upd;
  logic        lockup_q;

  // A shift coinciding with a seed write is dropped, not deferred
  always_comb begin
    cand = lfsr_q;
    upd  = 1'b0;
    unique case (1'b1)
      req_i.seed_we: begin
        cand = wdata_i;
        upd  = 1'b1;
      end
      (!req_i.seed_we && req_i.shift): begin
        cand = lfsr_step(lfsr_q, POLY);
        upd  = 1'b1;
      end
      default: begin
        cand = lfsr_q;
        upd  = 1'b0;
      end
    endcase
  end

  assign lock_evt_o = upd && (cand == 32'h0);
  assign lfsr_d     = lock_evt_o ? SEED : cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= SEED;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      lockup_q <= lock_evt_o;
    end
  end

  assign lfsr_o   = lfsr_q;
  assign lockup_o = lockup_q;

endmodule

// File: rtl/cv32e40s_lfsr_ctrl.sv
// Owns the three security LFSRs and the dummy counter-reset pulse.
// Define CV32E40S_LFSR_LOCKUP_ALERT_EN for alert_minor_o / lockup_seen_o.
module cv32e40s_lfsr_ctrl
  import cv32e40s_lfsr_ctrl_pkg::*;
#(
  parameter logic [31:0] LFSR0_SEED = LFSR0_SEED_DEFAULT,
  parameter logic [31:0] LFSR1_SEED = LFSR1_SEED_DEFAULT,
  parameter logic [31:0] LFSR2_SEED = LFSR2_SEED_DEFAULT,
  parameter logic [31:0] LFSR_POLY  = LFSR_POLY_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  cv32e40s_lfsr_ctrl_if.slave bus
);

  lfsr_req_t   req0;
  lfsr_req_t   req1;
  lfsr_req_t   req2;
  logic [2:0]  lock_evt;
  logic [2:0]  lockup;
  logic [31:0] lfsr0;
  logic [31:0] lfsr1;
  logic [31:0] lfsr2;
  logic        cntrst_q;
  logic        cntrst_d;

  assign req0 = '{seed_we: bus.seed_we_i[0], shift: bus.shift_i[0]};
  assign req1 = '{seed_we: bus.seed_we_i[1], shift: bus.shift_i[1]};
  assign req2 = '{seed_we: bus.seed_we_i[2], shift: bus.shift_i[2]};

  cv32e40s_lfsr #(
    .SEED (LFSR0_SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req0),
    .wdata_i    (bus.seed_wdata_i),
    .lfsr_o     (lfsr0),
    .lockup_o   (lockup[0]),
    .lock_evt_o (lock_evt[0])
  );

  cv32e40s_lfsr #(
    .SEED (LFSR1_SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req1),
    .wdata_i    (bus.seed_wdata_i),
    .lfsr_o     (lfsr1),
    .lockup_o   (lockup[1]),
    .lock_evt_o (lock_evt[1])
  );

  cv32e40s_lfsr #(
    .SEED (LFSR2_SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req2),
    .wdata_i    (bus.seed_wdata_i),
    .lfsr_o     (lfsr2),
    .lockup_o   (lockup[2]),
    .lock_evt_o (lock_evt[2])
  );

  // Only lfsr0 drives dummy cadence, so only its reseed restarts the counter
  assign cntrst_d = bus.cpuctrl_we_i | bus.seed_we_i[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntrst_q <= 1'b0;
    end else begin
      cntrst_q <= cntrst_d;
    end
  end

  assign bus.lfsr0_o  = lfsr0;
  assign bus.lfsr1_o  = lfsr1;
  assign bus.lfsr2_o  = lfsr2;
  assign bus.cntrst_o = cntrst_q;
  assign bus.lockup_o = lockup;

`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
  logic       alert_q;
  logic [2:0] seen_q;
  logic [2:0] seen_d;

  assign seen_d = seen_q | lock_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_q <= 1'b0;
      seen_q  <= 3'b000;
    end else begin
      alert_q <= |lock_evt;
      seen_q  <= seen_d;
    end
  end

  assign bus.alert_minor_o = alert_q;
  assign bus.lockup_seen_o = seen_q;
`endif

endmodule

// File: tb/tb_cv32e40s_lfsr_ctrl.sv
// Scoreboard bench for cv32e40s_lfsr_ctrl against a behavioural model.
// Define CV32E40S_LFSR_LOCKUP_ALERT_EN to also check the alert outputs.
module tb_cv32e40s_lfsr_ctrl;

  typedef struct {
    logic [31:0] lfsr [3];
    logic        cntrst;
    logic [2:0]  lockup;
    logic        alert;
    logic [2:0]  seen;
  } exp_t;

  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] seeds [3];
  logic [31:0] m_lfsr [3];
  logic [2:0]  m_seen;
  exp_t        exp_q [$];

  cv32e40s_lfsr_ctrl_if bus ();

  cv32e40s_lfsr_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 3; n++) m_lfsr[n] = seeds[n];
    m_seen = 3'b000;
  endtask

  task automatic drive(input logic [2:0] sw, input logic [31:0] wd,
                       input logic cw, input logic [2:0] sh);
    exp_t        e;
    logic [31:0] cand;
    @(negedge clk);
    bus.seed_we_i    = sw;
    bus.seed_wdata_i = wd;
    bus.cpuctrl_we_i = cw;
    bus.shift_i      = sh;
    e.lockup = 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (sw[n] || sh[n]) begin
        cand = sw[n] ? wd : m_step(m_lfsr[n]);
        if (cand == 32'h0) begin
          e.lockup[n] = 1'b1;
          cand = seeds[n];
        end
        m_lfsr[n] = cand;
      end
      e.lfsr[n] = m_lfsr[n];
    end
    m_seen   = m_seen | e.lockup;
    e.seen   = m_seen;
    e.alert  = |e.lockup;
    e.cntrst = cw | sw[0];
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(3'b000, 32'h0, 1'b0, 3'b000);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.seed_we_i    = 3'b000;
    bus.seed_wdata_i = 32'h0;
    bus.cpuctrl_we_i = 1'b0;
    bus.shift_i      = 3'b000;
    #1;
    chk("rst_lfsr0", bus.lfsr0_o, seeds[0]);
    chk("rst_lfsr1", bus.lfsr1_o, seeds[1]);
    chk("rst_lfsr2", bus.lfsr2_o, seeds[2]);
    chk("rst_cntrst", {31'h0, bus.cntrst_o}, 32'h0);
    chk("rst_lockup", {29'h0, bus.lockup_o}, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares one expected entry per cycle after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_lfsr0", bus.lfsr0_o, e.lfsr[0]);
        chk("sb_lfsr1", bus.lfsr1_o, e.lfsr[1]);
        chk("sb_lfsr2", bus.lfsr2_o, e.lfsr[2]);
        chk("sb_cntrst", {31'h0, bus.cntrst_o}, {31'h0, e.cntrst});
        chk("sb_lockup", {29'h0, bus.lockup_o}, {29'h0, e.lockup});
`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
        chk("sb_alert", {31'h0, bus.alert_minor_o}, {31'h0, e.alert});
        chk("sb_seen", {29'h0, bus.lockup_seen_o}, {29'h0, e.seen});
`endif
      end
    end
  end

  initial begin
    logic [2:0]  sw;
    logic [31:0] wd;
    logic [2:0]  sh;
    logic        cw;
    int          wait_cnt;
    checks = 0;
    errors = 0;
    seeds[0] = 32'h1234_5678;
    seeds[1] = 32'h9ABC_DEF0;
    seeds[2] = 32'h0F1E_2D3C;
    m_reset();
    rst_n = 1'b0;
    bus.seed_we_i    = 3'b000;
    bus.seed_wdata_i = 32'h0;
    bus.cpuctrl_we_i = 1'b0;
    bus.shift_i      = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release with no requests
    idle();
    settle();
    chk("init_lfsr0", bus.lfsr0_o, 32'h1234_5678);
    chk("init_lfsr1", bus.lfsr1_o, 32'h9ABC_DEF0);
    chk("init_lfsr2", bus.lfsr2_o, 32'h0F1E_2D3C);
    chk("init_cntrst", {31'h0, bus.cntrst_o}, 32'h0);

    // Seed lfsr0 with 1 then shift
    drive(3'b001, 32'h0000_0001, 1'b0, 3'b000);
    settle();
    chk("seed0_val", bus.lfsr0_o, 32'h0000_0001);
    chk("seed0_cntrst", {31'h0, bus.cntrst_o}, 32'h1);
    drive(3'b000, 32'h0, 1'b0, 3'b001);
    settle();
    chk("shift0_val", bus.lfsr0_o, 32'h8020_0003);
    chk("shift0_cntrst", {31'h0, bus.cntrst_o}, 32'h0);

    // Seed and shift together on lfsr1: shift dropped
    drive(3'b010, 32'h0000_0002, 1'b0, 3'b010);
    settle();
    chk("seedshift1", bus.lfsr1_o, 32'h0000_0002);
    chk("seed1_cntrst", {31'h0, bus.cntrst_o}, 32'h0);
    drive(3'b000, 32'h0, 1'b0, 3'b010);
    settle();
    chk("shift1_val", bus.lfsr1_o, 32'h0000_0001);

    // Zero seed on lfsr2 triggers recovery
    drive(3'b100, 32'h0, 1'b0, 3'b000);
    settle();
    chk("lock2_val", bus.lfsr2_o, 32'h0F1E_2D3C);
    chk("lock2_pulse", {29'h0, bus.lockup_o}, 32'h4);
`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
    chk("lock2_alert", {31'h0, bus.alert_minor_o}, 32'h1);
`endif
    idle();
    settle();
    chk("lock2_clear", {29'h0, bus.lockup_o}, 32'h0);
`ifdef CV32E40S_LFSR_LOCKUP_ALERT_EN
    chk("lock2_alert_clr", {31'h0, bus.alert_minor_o}, 32'h0);
    chk("lock2_seen", {29'h0, bus.lockup_seen_o}, 32'h4);
`endif

    // cpuctrl writes back to back
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 32'h0, 1'b1, 3'b000);
      settle();
      chk("cpuctrl_cntrst", {31'h0, bus.cntrst_o}, 32'h1);
    end
    drive(3'b110, 32'hA5A5_0001, 1'b0, 3'b000);
    settle();
    chk("seed12_cntrst", {31'h0, bus.cntrst_o}, 32'h0);
    chk("seed12_lfsr1", bus.lfsr1_o, 32'hA5A5_0001);
    chk("seed12_lfsr2", bus.lfsr2_o, 32'hA5A5_0001);

    // Long free-running shift from reset
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive(3'b000, 32'h0, 1'b0, 3'b111);
      if (i % 100 == 99) begin
        settle();
        chk("run_nz0", {31'h0, bus.lfsr0_o != 32'h0}, 32'h1);
        chk("run_nz1", {31'h0, bus.lfsr1_o != 32'h0}, 32'h1);
        chk("run_nz2", {31'h0, bus.lfsr2_o != 32'h0}, 32'h1);
      end
    end

    // Randomised traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      sw = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cw = ($urandom_range(0, 7) == 0);
      sh = 3'($urandom);
      drive(sw, wd, cw, sh);
      if (i == 700) do_reset();
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
